// File: rtl/arbitro_mux4_pkg.sv
// Shared constants and helpers for the four-requester multiplexor arbiter.
// State encodings stay plain 1-bit constants so legacy netlists keep matching.
package arbitro_mux4_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  localparam logic REPOSO    = 1'b0;
  localparam logic CONCEDIDO = 1'b1;

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/arbitro_mux4_rr_prioridad.sv
// Round-robin pick: first set request searching ptr+1, ptr+2, ptr+3, ptr (mod 4).
// Purely combinational; shared by the idle path and the end-of-burst path.
module rr_prioridad
  import arbitro_mux4_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] win,
  output logic             hay
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    win  = ptr;
    hay  = 1'b0;
    cand = '0;
    // Walk from farthest to nearest so the nearest candidate is written last and wins.
    for (int k = N_REQ; k >= 1; k--) begin
      cand = ptr + IDX_W'(k);
      if (req[cand]) begin
        win = cand;
        hay = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbitro_mux4.sv
// Round-robin arbiter in front of a 4:1 single-bit multiplexor: bounded bursts,
// back-to-back handover, and a registered, validated capture of the mux output.
module arbitro_mux4
  import arbitro_mux4_pkg::*;
#(
  parameter int MAX_RAFAGA = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       sal,
  output logic       sel0,
  output logic       sel1,
  output logic [3:0] gnt,
  output logic       activo,
  output logic       dato,
  output logic       dato_valido
);

  localparam logic [3:0] MAX_C = 4'(MAX_RAFAGA);

  logic             estado_q, estado_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [3:0]       cont_q, cont_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             dato_q, dato_d;
  logic             dato_valido_q, dato_valido_d;

  logic [IDX_W-1:0] ptr_arb;
  logic [IDX_W-1:0] win;
  logic             hay;
  logic             fin;
  logic             activo_int;

  // While granted, the held index is the pointer a burst end rotates from.
  assign ptr_arb    = (estado_q == CONCEDIDO) ? sel_q : ptr_q;
  assign activo_int = |gnt_q;

  rr_prioridad u_rr (
    .req (req),
    .ptr (ptr_arb),
    .win (win),
    .hay (hay)
  );

  always_comb begin
    estado_d = estado_q;
    ptr_d    = ptr_q;
    sel_d    = sel_q;
    cont_d   = cont_q;
    gnt_d    = gnt_q;
    fin      = 1'b0;

    if (estado_q == REPOSO) begin
      if (hay) begin
        estado_d = CONCEDIDO;
        gnt_d    = onehot(win);
        sel_d    = win;
        cont_d   = 4'd1;
      end else begin
        gnt_d = '0;
      end
    end else begin
      fin = !req[sel_q] || (cont_q == MAX_C);
      if (fin) begin
        ptr_d = sel_q;
        if (hay) begin
          gnt_d  = onehot(win);
          sel_d  = win;
          cont_d = 4'd1;
        end else begin
          estado_d = REPOSO;
          gnt_d    = '0;
          cont_d   = 4'd0;
        end
      end else begin
        cont_d = cont_q + 4'd1;
      end
    end

    dato_d        = activo_int ? sal : dato_q;
    dato_valido_d = activo_int;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado_q      <= REPOSO;
      ptr_q         <= 2'd3;
      sel_q         <= '0;
      cont_q        <= '0;
      gnt_q         <= '0;
      dato_q        <= 1'b0;
      dato_valido_q <= 1'b0;
    end else begin
      estado_q      <= estado_d;
      ptr_q         <= ptr_d;
      sel_q         <= sel_d;
      cont_q        <= cont_d;
      gnt_q         <= gnt_d;
      dato_q        <= dato_d;
      dato_valido_q <= dato_valido_d;
    end
  end

  assign sel0        = sel_q[0];
  assign sel1        = sel_q[1];
  assign gnt         = gnt_q;
  assign activo      = activo_int;
  assign dato        = dato_q;
  assign dato_valido = dato_valido_q;

endmodule
